// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64I decode stage: extracts fields and the sign-extended immediate,
// flags illegal encodings, and buffers results in a main + skid register pair.
module rv_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [11:0]      out_funct12,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_decode_error,
  output logic [CNT_W-1:0] error_count
);

  localparam bit Rv64 = (XLEN == 64);

  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;
  localparam logic [6:0] OpImm32   = 7'b0011011;
  localparam logic [6:0] Op32      = 7'b0111011;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            err;
  } entry_t;

  logic [6:0]       w_opcode;
  logic [2:0]       w_f3;
  logic [31:0]      w_imm32;
  logic             w_err;
  entry_t           w_in_entry;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_free;

  entry_t           r_main;
  entry_t           r_skid;
  logic             r_main_v;
  logic             r_skid_v;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_opcode = in_inst[6:0];
  assign w_f3     = in_inst[14:12];

  always_comb begin
    w_imm32 = '0;
    w_err   = 1'b0;
    case (w_opcode)
      OpLui, OpAuipc: w_imm32 = {in_inst[31:12], 12'b0};
      OpJal: w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                        in_inst[30:21], 1'b0};
      OpJalr: begin
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        w_err   = (w_f3 != 3'b000);
      end
      OpBranch: begin
        w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
        w_err   = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OpLoad: begin
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        w_err   = (w_f3 == 3'b111) || (!Rv64 && ((w_f3 == 3'b011) || (w_f3 == 3'b110)));
      end
      OpStore: begin
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        w_err   = w_f3[2] || (!Rv64 && (w_f3 == 3'b011));
      end
      OpImm: begin
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        // RV32 shift amounts are 5 bits; shamt[5] set is reserved
        w_err   = !Rv64 && ((w_f3 == 3'b001) || (w_f3 == 3'b101)) && in_inst[25];
      end
      OpOp: w_imm32 = '0;
      OpMiscMem, OpSystem: w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      OpImm32: begin
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        w_err   = !Rv64;
      end
      Op32: w_err = !Rv64;
      default: w_err = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) w_err = 1'b1;
  end

  assign w_in_entry = '{inst: in_inst, pc: in_pc, imm: XLEN'($signed(w_imm32)), err: w_err};

  // in_ready is a pure function of the skid flop, so it is registered by construction
  assign in_ready    = !r_skid_v;
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = r_main_v && out_ready;
  assign w_main_free = !r_main_v || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_v) begin
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else begin
        r_main_v <= w_in_fire;
        if (w_in_fire) r_main <= w_in_entry;
      end
    end else if (w_in_fire) begin
      r_skid   <= w_in_entry;
      r_skid_v <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_out_fire && r_main.err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign out_valid        = r_main_v;
  assign out_inst         = r_main.inst;
  assign out_pc           = r_main.pc;
  assign out_opcode       = r_main.inst[6:0];
  assign out_rd           = r_main.inst[11:7];
  assign out_rs1          = r_main.inst[19:15];
  assign out_rs2          = r_main.inst[24:20];
  assign out_funct3       = r_main.inst[14:12];
  assign out_funct7       = r_main.inst[31:25];
  assign out_funct12      = r_main.inst[31:20];
  assign out_imm          = r_main.imm;
  assign out_decode_error = r_main.err;
  assign error_count      = r_err_cnt;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench: drives an RV32 instance and an RV64 (2-bit counter) instance with the
// same directed instruction stream and checks both output streams against expected queues.
module tb_rv_decode_stage;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    logic        e32;
    logic        e64;
  } vec_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm;
    logic        err;
  } exp_t;

  // Hand-decoded vectors: instruction, 32-bit immediate, error at XLEN=32, error at XLEN=64
  vec_t tbl [18] = '{
    '{32'hFFF00093, 32'hFFFFFFFF, 1'b0, 1'b0},  // addi x1,x0,-1
    '{32'h123452B7, 32'h12345000, 1'b0, 1'b0},  // lui x5
    '{32'hFFDFF0EF, 32'hFFFFFFFC, 1'b0, 1'b0},  // jal x1,-4
    '{32'h00000463, 32'h00000008, 1'b0, 1'b0},  // beq x0,x0,8
    '{32'h00000000, 32'h00000000, 1'b1, 1'b1},
    '{32'h0000003B, 32'h00000000, 1'b1, 1'b0},  // OP-32
    '{32'h00001067, 32'h00000000, 1'b1, 1'b1},  // jalr funct3=001
    '{32'h00002063, 32'h00000000, 1'b1, 1'b1},  // branch funct3=010
    '{32'h80003003, 32'hFFFFF800, 1'b1, 1'b0},  // ld
    '{32'h00007003, 32'h00000000, 1'b1, 1'b1},  // load funct3=111
    '{32'hFE20AE23, 32'hFFFFFFFC, 1'b0, 1'b0},  // sw x2,-4(x1)
    '{32'h00003023, 32'h00000000, 1'b1, 1'b0},  // sd
    '{32'h02001013, 32'h00000020, 1'b1, 1'b0},  // slli shamt=32
    '{32'hFFFFF517, 32'hFFFFF000, 1'b0, 1'b0},  // auipc x10
    '{32'h0FF0000F, 32'h000000FF, 1'b0, 1'b0},  // fence
    '{32'h003100B3, 32'h00000000, 1'b0, 1'b0},  // add
    '{32'hFE209EE3, 32'hFFFFFFFC, 1'b0, 1'b0},  // bne x1,x2,-4
    '{32'h00000073, 32'h00000000, 1'b0, 1'b0}   // ecall
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] pc32 = '0;
  logic [63:0] pc64 = '0;
  logic        out_ready = 1'b1;

  logic        in_ready32, out_valid32, err32;
  logic [31:0] inst32, opc_pc32, imm32;
  logic [6:0]  opc32, f7_32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32;
  logic [11:0] f12_32;
  logic [15:0] cnt32;

  logic        in_ready64, out_valid64, err64;
  logic [31:0] inst64;
  logic [63:0] opc_pc64, imm64;
  logic [6:0]  opc64, f7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64;
  logic [11:0] f12_64;
  logic [1:0]  cnt64;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q32[$];
  exp_t q64[$];
  logic [15:0] m_cnt32 = '0;
  logic [1:0]  m_cnt64 = '0;
  logic [31:0] r_pc = 32'h0000_1000;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .CNT_W(16)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_pc(pc32), .out_valid(out_valid32), .out_ready(out_ready),
    .out_inst(inst32), .out_pc(opc_pc32), .out_opcode(opc32), .out_rd(rd32),
    .out_rs1(rs1_32), .out_rs2(rs2_32), .out_funct3(f3_32), .out_funct7(f7_32),
    .out_funct12(f12_32), .out_imm(imm32), .out_decode_error(err32), .error_count(cnt32)
  );

  rv_decode_stage #(.XLEN(64), .CNT_W(2)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc(pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_inst(inst64), .out_pc(opc_pc64), .out_opcode(opc64), .out_rd(rd64),
    .out_rs1(rs1_64), .out_rs2(rs2_64), .out_funct3(f3_64), .out_funct7(f7_64),
    .out_funct12(f12_64), .out_imm(imm64), .out_decode_error(err64), .error_count(cnt64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e, input logic [31:0] inst,
                         input logic [63:0] pc, input logic [6:0] opc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [11:0] f12,
                         input logic [63:0] imm, input logic err);
    logic [31:0] i;
    i = e.inst;
    chk({tag, "_inst"}, inst, i);
    chk({tag, "_pc"}, pc, e.pc);
    chk({tag, "_opcode"}, opc, i[6:0]);
    chk({tag, "_rd"}, rd, i[11:7]);
    chk({tag, "_rs1"}, rs1, i[19:15]);
    chk({tag, "_rs2"}, rs2, i[24:20]);
    chk({tag, "_funct3"}, f3, i[14:12]);
    chk({tag, "_funct7"}, f7, i[31:25]);
    chk({tag, "_funct12"}, f12, i[31:20]);
    chk({tag, "_imm"}, imm, e.imm);
    chk({tag, "_err"}, err, e.err);
  endtask

  // Monitor: the head of each queue must be presented whenever out_valid is high
  always @(negedge clk) begin
    if (rst) begin
      q32.delete();
      q64.delete();
      m_cnt32 = '0;
      m_cnt64 = '0;
    end else begin
      chk("errcnt32", cnt32, m_cnt32);
      chk("errcnt64", cnt64, m_cnt64);
      if (out_valid32) begin
        if (q32.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious32: got inst %h, expected no output", inst32);
        end else begin
          chk_out("d32", q32[0], inst32, opc_pc32, opc32, rd32, rs1_32, rs2_32, f3_32, f7_32,
                  f12_32, imm32, err32);
          if (out_ready) begin
            if (q32[0].err && m_cnt32 != '1) m_cnt32 = m_cnt32 + 16'd1;
            void'(q32.pop_front());
          end
        end
      end
      if (out_valid64) begin
        if (q64.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious64: got inst %h, expected no output", inst64);
        end else begin
          chk_out("d64", q64[0], inst64, opc_pc64, opc64, rd64, rs1_64, rs2_64, f3_64, f7_64,
                  f12_64, imm64, err64);
          if (out_ready) begin
            if (q64[0].err && m_cnt64 != '1) m_cnt64 = m_cnt64 + 2'd1;
            void'(q64.pop_front());
          end
        end
      end
      if (flush) begin
        q32.delete();
        q64.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one vector and return just after the edge that accepts it
  task automatic put(input int idx);
    int t;
    exp_t e;
    t = 0;
    in_valid = 1'b1;
    in_inst  = tbl[idx].inst;
    pc32     = r_pc;
    pc64     = {32'hCAFE_0000, r_pc};
    while (!in_ready32 && t < 20) begin
      tick();
      t++;
    end
    if (!in_ready32) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", t);
      in_valid = 1'b0;
      return;
    end
    e.inst = tbl[idx].inst; e.pc = {32'h0, r_pc}; e.imm = {32'h0, tbl[idx].imm};
    e.err = tbl[idx].e32;
    q32.push_back(e);
    e.pc = pc64; e.imm = {{32{tbl[idx].imm[31]}}, tbl[idx].imm}; e.err = tbl[idx].e64;
    q64.push_back(e);
    tick();
    r_pc = r_pc + 32'd4;
  endtask

  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    repeat (2) tick();
    chk("rst_out_valid", out_valid32, 1'b0);
    chk("rst_in_ready", in_ready32, 1'b1);
    chk("rst_errcnt", cnt32, 16'd0);
    chk("rst_inst", inst32, 32'd0);
    chk("rst_imm64", imm64, 64'd0);
    rst = 1'b0;
    tick();

    put(0);
    in_valid = 1'b0;
    repeat (3) tick();

    // Back-to-back: one word per cycle, in_ready never drops
    for (int k = 1; k <= 3; k++) begin
      put(k);
      chk("b2b_in_ready", in_ready32, 1'b1);
    end
    in_valid = 1'b0;
    repeat (3) tick();

    put(4);
    put(5);
    in_valid = 1'b0;
    repeat (3) tick();
    chk("err_pair_cnt32", cnt32, 16'd2);
    chk("err_pair_cnt64", cnt64, 2'd1);

    // Stall: main + skid fill, in_ready drops, then drain in order
    out_ready = 1'b0;
    put(13);
    chk("stall_in_ready_1", in_ready32, 1'b1);
    put(14);
    chk("stall_in_ready_2", in_ready32, 1'b0);
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    put(15);
    put(16);
    in_valid = 1'b0;
    repeat (3) tick();

    for (int k = 6; k <= 12; k++) put(k);
    put(17);
    in_valid = 1'b0;
    repeat (3) tick();

    // Irregular consumer pattern
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          out_ready = (i % 3) != 0;
          tick();
        end
        out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 10; k++) put(k);
        in_valid = 1'b0;
      end
    join
    repeat (4) tick();

    // Flush with both entries full and a word presented
    out_ready = 1'b0;
    put(4);
    put(5);
    in_valid = 1'b1;
    in_inst  = tbl[3].inst;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_full_out_valid", out_valid32, 1'b0);
    chk("flush_full_in_ready", in_ready32, 1'b1);
    out_ready = 1'b1;
    put(13);
    in_valid = 1'b0;
    repeat (3) tick();

    // Flush while a same-cycle input transfer would otherwise land in skid
    out_ready = 1'b0;
    put(1);
    in_valid = 1'b1;
    in_inst  = tbl[2].inst;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_one_out_valid", out_valid32, 1'b0);
    chk("flush_one_in_ready", in_ready32, 1'b1);
    out_ready = 1'b1;
    put(14);
    in_valid = 1'b0;
    repeat (3) tick();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    put(4);
    put(6);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid32, 1'b0);
    chk("arst_in_ready", in_ready32, 1'b1);
    chk("arst_errcnt32", cnt32, 16'd0);
    chk("arst_errcnt64", cnt64, 2'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      put(4);
      in_valid = 1'b0;
      tick();
      chk("sat_cnt64", cnt64, sat_exp[i]);
      chk("sat_cnt32", cnt32, 16'(i + 1));
    end

    repeat (5) tick();
    chk("q32_drained", q32.size(), 0);
    chk("q64_drained", q64.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
